// File: rtl/haze_pass_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// haze_pkg
// Shared definitions for the haze two-pass sequencer slice: sequencer state
// encoding, default frame geometry and the counter-width helper.
// ---------------------------------------------------------------------------
package haze_pkg;

  localparam int HAZE_IMG_WIDTH  = 512;
  localparam int HAZE_IMG_HEIGHT = 512;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PASS1    = 3'd1,
    ALE_WAIT = 3'd2,
    PASS2    = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } seq_state_t;

  // Width of a counter that must hold values 0..max_val with one spare bit.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/haze_pass_sequencer_if.sv
// ---------------------------------------------------------------------------
// haze_pass_sequencer_if
// Groups the pixel stream, datapath strobe and output-monitor signals.
//   master : the sequencer's view (drives TREADY, core_* strobes, M TLAST)
//   slave  : the environment/datapath view (drives TVALID/TLAST, core_ready,
//            ale_done and the monitored M_AXIS handshake)
// ---------------------------------------------------------------------------
interface haze_pass_sequencer_if;

  logic S_AXIS_TVALID;
  logic S_AXIS_TLAST;
  logic S_AXIS_TREADY;
  logic core_ready;
  logic core_valid;
  logic core_pass;
  logic core_sof;
  logic core_eol;
  logic core_eof;
  logic ale_done;
  logic M_AXIS_TVALID;
  logic M_AXIS_TREADY;
  logic M_AXIS_TLAST;

  modport master (
    input  S_AXIS_TVALID, S_AXIS_TLAST, core_ready, ale_done,
           M_AXIS_TVALID, M_AXIS_TREADY,
    output S_AXIS_TREADY, core_valid, core_pass, core_sof, core_eol,
           core_eof, M_AXIS_TLAST
  );

  modport slave (
    output S_AXIS_TVALID, S_AXIS_TLAST, core_ready, ale_done,
           M_AXIS_TVALID, M_AXIS_TREADY,
    input  S_AXIS_TREADY, core_valid, core_pass, core_sof, core_eol,
           core_eof, M_AXIS_TLAST
  );

endinterface

// File: rtl/haze_xy_counter.sv
// ---------------------------------------------------------------------------
// haze_xy_counter
// Raster position of the next input pixel with wrap at end of line/frame.
// Ports:
//   ACLK, ARESET : clock, synchronous active-high reset
//   clr          : return to (0,0) (frame start)
//   inc          : one pixel accepted; advance raster position
//   sof/eol/eof  : current position is first pixel / last of line / last of frame
// ---------------------------------------------------------------------------
module haze_xy_counter
  import haze_pkg::*;
#(
  parameter int IMG_WIDTH  = HAZE_IMG_WIDTH,
  parameter int IMG_HEIGHT = HAZE_IMG_HEIGHT
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic clr,
  input  logic inc,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int XW = cnt_width(IMG_WIDTH - 1);
  localparam int YW = cnt_width(IMG_HEIGHT - 1);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic          eol_s;
  logic          eof_s;

  assign eol_s = (x_r == XW'(IMG_WIDTH - 1));
  assign eof_s = eol_s && (y_r == YW'(IMG_HEIGHT - 1));

  // Position register: cleared at frame start, advanced per accepted pixel.
  always_ff @(posedge ACLK) begin
    if (ARESET || clr) begin
      x_r <= {XW{1'b0}};
      y_r <= {YW{1'b0}};
    end else if (inc) begin
      if (eol_s) begin
        x_r <= {XW{1'b0}};
        y_r <= eof_s ? {YW{1'b0}} : (y_r + YW'(1));
      end else begin
        x_r <= x_r + XW'(1);
      end
    end
  end

  assign sof = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
  assign eol = eol_s;
  assign eof = eof_s;

endmodule

// File: rtl/haze_pass_sequencer.sv
// ---------------------------------------------------------------------------
// haze_pass_sequencer
// Runs each frame through the datapath twice: an ALE pass, a wait for the
// ALE result, then a TE/SRSC pass, after which it waits for the full frame
// to leave on the monitored output stream before reporting completion.
// Ports:
//   ACLK, ARESET            : clock, synchronous active-high reset
//   enable                  : run enable; low freezes all state
//   start                   : frame start request (used only when idle)
//   bus (master)            : pixel stream, datapath strobes, output monitor
//   busy, frame_done        : not idle; one-cycle completion pulse
//   err_tlast               : sticky input TLAST/frame-end disagreement
// ---------------------------------------------------------------------------
module haze_pass_sequencer
  import haze_pkg::*;
#(
  parameter int IMG_WIDTH  = HAZE_IMG_WIDTH,
  parameter int IMG_HEIGHT = HAZE_IMG_HEIGHT
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   enable,
  input  logic                   start,
  haze_pass_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_tlast
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int OW   = cnt_width(NPIX);

  seq_state_t    state_r;
  seq_state_t    state_nxt_s;
  logic [OW-1:0] out_cnt_r;
  logic          err_tlast_r;
  logic          in_pass_s;
  logic          out_phase_s;
  logic          tready_s;
  logic          beat_s;
  logic          out_beat_s;
  logic          start_frame_s;
  logic          sof_s;
  logic          eol_s;
  logic          eof_s;

  assign in_pass_s     = (state_r == PASS1) || (state_r == PASS2);
  assign out_phase_s   = (state_r == PASS2) || (state_r == DRAIN);
  // Reset gating keeps every combinational output low while ARESET is held.
  assign tready_s      = !ARESET && enable && bus.core_ready && in_pass_s;
  assign beat_s        = tready_s && bus.S_AXIS_TVALID;
  assign start_frame_s = enable && (state_r == IDLE) && start;
  // Saturate at a full frame so a stray extra beat cannot wrap the count.
  assign out_beat_s    = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && out_phase_s &&
                         (out_cnt_r != OW'(NPIX));

  haze_xy_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_xy (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clr    (start_frame_s),
    .inc    (beat_s),
    .sof    (sof_s),
    .eol    (eol_s),
    .eof    (eof_s)
  );

  // Next-state logic for the two-pass frame sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     if (start)                         state_nxt_s = PASS1;
                else                               state_nxt_s = IDLE;
      PASS1:    if (beat_s && eof_s)               state_nxt_s = ALE_WAIT;
                else                               state_nxt_s = PASS1;
      ALE_WAIT: if (bus.ale_done)                  state_nxt_s = PASS2;
                else                               state_nxt_s = ALE_WAIT;
      PASS2:    if (beat_s && eof_s)               state_nxt_s = DRAIN;
                else                               state_nxt_s = PASS2;
      DRAIN:    if (out_cnt_r == OW'(NPIX))        state_nxt_s = DONE;
                else                               state_nxt_s = DRAIN;
      DONE:                                        state_nxt_s = IDLE;
      default:                                     state_nxt_s = IDLE;
    endcase
  end

  // State, output-beat counter and sticky TLAST error; all frozen when disabled.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r     <= IDLE;
      out_cnt_r   <= {OW{1'b0}};
      err_tlast_r <= 1'b0;
    end else if (enable) begin
      state_r <= state_nxt_s;
      if (start_frame_s) begin
        out_cnt_r   <= {OW{1'b0}};
        err_tlast_r <= 1'b0;
      end else begin
        if (out_beat_s) begin
          out_cnt_r <= out_cnt_r + OW'(1);
        end
        if (beat_s && (bus.S_AXIS_TLAST != eof_s)) begin
          err_tlast_r <= 1'b1;
        end
      end
    end
  end

  assign bus.S_AXIS_TREADY = tready_s;
  assign bus.core_valid    = beat_s;
  assign bus.core_pass     = !ARESET && out_phase_s;
  assign bus.core_sof      = beat_s && sof_s;
  assign bus.core_eol      = beat_s && eol_s;
  assign bus.core_eof      = beat_s && eof_s;
  assign bus.M_AXIS_TLAST  = !ARESET && bus.M_AXIS_TVALID && (out_cnt_r == OW'(NPIX - 1));
  assign busy              = !ARESET && (state_r != IDLE);
  assign frame_done        = !ARESET && (state_r == DONE);
  assign err_tlast         = err_tlast_r;

endmodule

// File: tb/tb_haze_pass_sequencer.sv
// ---------------------------------------------------------------------------
// tb_haze_pass_sequencer
// Directed bench for haze_pass_sequencer at 4x2 pixels. A frame-level model
// (phase number, linear pixel index, output-beat count) predicts every
// output each cycle; literal masks pin the beat positions of the strobes.
// ---------------------------------------------------------------------------
module tb_haze_pass_sequencer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic ACLK = 1'b0;
  logic ARESET, enable, start;
  logic busy, frame_done, err_tlast;

  haze_pass_sequencer_if bus();

  haze_pass_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .enable     (enable),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .err_tlast  (err_tlast)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase: 0 idle, 1 pass one, 2 waiting for ALE, 3 pass two, 4 drain, 5 done
  int   m_phase = 0, m_idx = 0, m_ocnt = 0;
  logic m_err = 1'b0;
  bit   chk_on = 1'b0;
  bit   m_acc, m_obeat;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_phase = 0; m_idx = 0; m_ocnt = 0; m_err = 1'b0; chk_on = 1'b1;
    end else if (enable) begin
      m_acc   = bus.core_ready && bus.S_AXIS_TVALID && (m_phase == 1 || m_phase == 3);
      m_obeat = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && (m_phase == 3 || m_phase == 4);
      case (m_phase)
        0: if (start) begin m_phase = 1; m_idx = 0; m_ocnt = 0; m_err = 1'b0; end
        1, 3: if (m_acc) begin
          if (bus.S_AXIS_TLAST != (m_idx == N - 1)) m_err = 1'b1;
          if (m_idx == N - 1) begin m_idx = 0; m_phase = m_phase + 1; end
          else m_idx = m_idx + 1;
        end
        2: if (bus.ale_done) m_phase = 3;
        4: if (m_ocnt == N) m_phase = 5;
        5: m_phase = 0;
        default: m_phase = 0;
      endcase
      if (m_obeat && m_ocnt < N) m_ocnt = m_ocnt + 1;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  logic e_tr, e_cv;
  always @(negedge ACLK) begin
    if (chk_on) begin
      e_tr = !ARESET && enable && bus.core_ready && (m_phase == 1 || m_phase == 3);
      e_cv = e_tr && bus.S_AXIS_TVALID;
      chk("tready",     {31'd0, bus.S_AXIS_TREADY}, {31'd0, e_tr});
      chk("core_valid", {31'd0, bus.core_valid},    {31'd0, e_cv});
      chk("core_sof",   {31'd0, bus.core_sof},      {31'd0, e_cv && m_idx == 0});
      chk("core_eol",   {31'd0, bus.core_eol},      {31'd0, e_cv && (m_idx % W) == W - 1});
      chk("core_eof",   {31'd0, bus.core_eof},      {31'd0, e_cv && m_idx == N - 1});
      chk("core_pass",  {31'd0, bus.core_pass},     {31'd0, !ARESET && (m_phase == 3 || m_phase == 4)});
      chk("m_tlast",    {31'd0, bus.M_AXIS_TLAST},  {31'd0, !ARESET && bus.M_AXIS_TVALID && m_ocnt == N - 1});
      chk("busy",       {31'd0, busy},              {31'd0, !ARESET && m_phase != 0});
      chk("frame_done", {31'd0, frame_done},        {31'd0, !ARESET && m_phase == 5});
      chk("err_tlast",  {31'd0, err_tlast},         {31'd0, m_err});
    end
  end

  // ---------------- beat-position monitor for literal checks ----------------
  int          mon_beats, out_beats, mlast_at, fd_cnt;
  logic [31:0] sof_mask, eol_mask, eof_mask, pass_mask;

  always @(negedge ACLK) begin
    if (bus.core_valid === 1'b1) begin
      if (mon_beats < 32) begin
        sof_mask[mon_beats[4:0]]  = bus.core_sof;
        eol_mask[mon_beats[4:0]]  = bus.core_eol;
        eof_mask[mon_beats[4:0]]  = bus.core_eof;
        pass_mask[mon_beats[4:0]] = bus.core_pass;
      end
      mon_beats++;
    end
    if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
      out_beats++;
      if (bus.M_AXIS_TLAST === 1'b1) mlast_at = out_beats;
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic clr_mon();
    mon_beats = 0; out_beats = 0; mlast_at = 0; fd_cnt = 0;
    sof_mask = 32'd0; eol_mask = 32'd0; eof_mask = 32'd0; pass_mask = 32'd0;
  endtask

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_ale();
    bus.ale_done = 1'b1; cyc(); bus.ale_done = 1'b0;
  endtask

  // Offer beats until n are accepted; TLAST rides on accepted beat tlast_at.
  task automatic send_beats(input int n, input int tlast_at, input bit toggle);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 200) begin
      bus.S_AXIS_TVALID = 1'b1;
      bus.S_AXIS_TLAST  = (acc + 1 == tlast_at);
      bus.core_ready    = toggle ? ~bus.core_ready : 1'b1;
      @(negedge ACLK);
      if (bus.core_valid === 1'b1) acc++;
      cyc();
      guard++;
    end
    chk("send_timeout", acc, n);
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.core_ready    = 1'b1;
  endtask

  task automatic send_out(input int n);
    bus.M_AXIS_TVALID = 1'b1; bus.M_AXIS_TREADY = 1'b1;
    repeat (n) cyc();
    bus.M_AXIS_TVALID = 1'b0; bus.M_AXIS_TREADY = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    @(negedge ACLK);
    while (busy === 1'b1 && g < 12) begin @(negedge ACLK); g++; end
    chk("done_timeout", {31'd0, busy}, 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1; enable = 1'b1; start = 1'b0;
    bus.S_AXIS_TVALID = 1'b0; bus.S_AXIS_TLAST = 1'b0; bus.core_ready = 1'b1;
    bus.ale_done = 1'b0; bus.M_AXIS_TVALID = 1'b0; bus.M_AXIS_TREADY = 1'b0;
    clr_mon();
    repeat (3) cyc();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_busy",   {31'd0, busy},              32'd0);
    chk("rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    chk("rst_err",    {31'd0, err_tlast},         32'd0);
    cyc();

    // Full frame: two passes, output drain, completion pulse.
    clr_mon(); pulse_start();
    send_beats(8, 8, 1'b0);
    @(negedge ACLK); chk("t1_ale_wait_busy", {31'd0, busy}, 32'd1); cyc();
    pulse_ale();
    send_beats(8, 8, 1'b0);
    send_out(8);
    wait_done();
    chk("t1_beats",    mon_beats, 16);
    chk("t1_eof_mask", eof_mask,  32'h0000_8080);
    chk("t1_sof_mask", sof_mask,  32'h0000_0101);
    chk("t1_eol_mask", eol_mask,  32'h0000_8888);
    chk("t1_pass",     pass_mask, 32'h0000_FF00);
    chk("t1_mlast_at", mlast_at,  8);
    chk("t1_fd_cnt",   fd_cnt,    1);

    // ale_done during pass one is ignored.
    clr_mon(); pulse_start();
    send_beats(3, 0, 1'b0);
    pulse_ale();
    send_beats(5, 5, 1'b0);
    bus.S_AXIS_TVALID = 1'b1;
    repeat (4) begin
      @(negedge ACLK);
      chk("t2_hold_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
      chk("t2_hold_pass",   {31'd0, bus.core_pass},     32'd0);
      cyc();
    end
    bus.S_AXIS_TVALID = 1'b0;
    pulse_ale();
    @(negedge ACLK); chk("t2_pass2", {31'd0, bus.core_pass}, 32'd1); cyc();
    send_beats(8, 8, 1'b0);
    send_out(8);
    wait_done();
    chk("t2_eof_mask", eof_mask, 32'h0000_8080);
    chk("t2_fd_cnt",   fd_cnt,   1);

    // Early TLAST sets a sticky error; the next start clears it.
    clr_mon(); pulse_start();
    send_beats(8, 5, 1'b0);
    @(negedge ACLK); chk("t3_err_set", {31'd0, err_tlast}, 32'd1); cyc();
    pulse_ale();
    send_beats(8, 8, 1'b0);
    send_out(8);
    wait_done();
    chk("t3_err_sticky", {31'd0, err_tlast}, 32'd1);
    chk("t3_fd_cnt",     fd_cnt,             1);
    pulse_start();
    @(negedge ACLK); chk("t3_err_clear", {31'd0, err_tlast}, 32'd0); cyc();

    // enable low mid-line with TVALID held: nothing accepted, nothing lost.
    clr_mon();
    send_beats(2, 0, 1'b0);
    enable = 1'b0; bus.S_AXIS_TVALID = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      chk("t4_en_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
      chk("t4_en_valid",  {31'd0, bus.core_valid},    32'd0);
      cyc();
    end
    enable = 1'b1; bus.S_AXIS_TVALID = 1'b0;
    send_beats(6, 6, 1'b0);
    chk("t4_beats",    mon_beats, 8);
    chk("t4_eol_mask", eol_mask,  32'h0000_0088);
    chk("t4_eof_mask", eof_mask,  32'h0000_0080);

    // Reset in the middle of pass two, then a clean restart.
    pulse_ale();
    send_beats(2, 0, 1'b0);
    ARESET = 1'b1; bus.S_AXIS_TVALID = 1'b1;
    @(negedge ACLK);
    chk("t5_rst_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    chk("t5_rst_valid",  {31'd0, bus.core_valid},    32'd0);
    cyc();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("t5_busy",   {31'd0, busy},              32'd0);
    chk("t5_tready", {31'd0, bus.S_AXIS_TREADY}, 32'd0);
    cyc();
    bus.S_AXIS_TVALID = 1'b0;

    // Restarted frame with core_ready toggling every cycle in both passes.
    clr_mon(); pulse_start();
    send_beats(8, 8, 1'b1);
    chk("t6_p1_beats", mon_beats, 8);
    chk("t6_p1_sof",   sof_mask,  32'h0000_0001);
    chk("t6_p1_eol",   eol_mask,  32'h0000_0088);
    chk("t6_p1_pass",  pass_mask, 32'h0000_0000);
    pulse_ale();
    clr_mon();
    send_beats(8, 8, 1'b1);
    chk("t6_p2_beats", mon_beats, 8);
    chk("t6_p2_eol",   eol_mask,  32'h0000_0088);
    chk("t6_p2_pass",  pass_mask, 32'h0000_00FF);
    send_out(8);
    wait_done();
    chk("t6_mlast_at", mlast_at, 8);
    chk("t6_fd_cnt",   fd_cnt,   1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/haze_pass_sequencer.md
HAZE_PASS_SEQUENCER -- requirements
Module: haze_pass_sequencer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 512, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 512, lines per frame.
REQ-003 SHALL have port ACLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  global run enable; low freezes all state.
REQ-006 SHALL have port start  in  1  frame start request, sampled only in IDLE.
REQ-007 SHALL have port S_AXIS_TVALID  in  1  upstream pixel valid.
REQ-008 SHALL have port S_AXIS_TLAST  in  1  upstream end-of-frame marker.
REQ-009 SHALL have port S_AXIS_TREADY  out  1  upstream ready.
REQ-010 SHALL have port core_ready  in  1  datapath can accept a pixel.
REQ-011 SHALL have port core_valid  out  1  pixel accepted this cycle.
REQ-012 SHALL have port core_pass  out  1  0 = ALE pass, 1 = TE/SRSC pass.
REQ-013 SHALL have ports core_sof, core_eol, core_eof  out  1 each  first pixel, last pixel of line, last pixel of frame, all qualified by core_valid.
REQ-014 SHALL have port ale_done  in  1  ALE result latched by the datapath.
REQ-015 SHALL have ports M_AXIS_TVALID, M_AXIS_TREADY  in  1 each  monitored output handshake.
REQ-016 SHALL have port M_AXIS_TLAST  out  1  last output beat of the frame.
REQ-017 SHALL have ports busy, frame_done, err_tlast  out  1 each  not IDLE; 1-cycle completion pulse; sticky TLAST mismatch flag.

Function
REQ-018 SHALL implement states IDLE, PASS1, ALE_WAIT, PASS2, DRAIN, DONE.
REQ-019 SHALL move IDLE->PASS1 on start=1, clearing x/y/output counters and err_tlast.
REQ-020 SHALL drive S_AXIS_TREADY = enable & core_ready & (state is PASS1 or PASS2), combinationally.
REQ-021 SHALL drive core_valid = S_AXIS_TVALID & S_AXIS_TREADY (an accepted beat), with zero latency.
REQ-022 SHALL increment x on each accepted beat; at x = IMG_WIDTH-1, wrap x to 0 and increment y.
REQ-023 SHALL, on the beat at x = IMG_WIDTH-1 and y = IMG_HEIGHT-1, wrap x/y to 0 and go PASS1->ALE_WAIT or PASS2->DRAIN.
REQ-024 SHALL assert core_sof at (0,0), core_eol at x = IMG_WIDTH-1, and core_eof at the last pixel; each is gated by core_valid.
REQ-025 SHALL drive core_pass = 1 in PASS2 and DRAIN, and 0 otherwise.
REQ-026 SHALL go ALE_WAIT->PASS2 on ale_done=1; ale_done in any other state SHALL be ignored.
REQ-027 SHALL count output beats (M_AXIS_TVALID & M_AXIS_TREADY) only in PASS2 and DRAIN.
REQ-028 SHALL drive M_AXIS_TLAST = M_AXIS_TVALID when the output count = IMG_WIDTH*IMG_HEIGHT-1.
REQ-029 SHALL go DRAIN->DONE once the output count reaches IMG_WIDTH*IMG_HEIGHT; the final beat arriving in PASS2 SHALL be counted and transition taken from DRAIN next cycle.
REQ-030 SHALL pulse frame_done for exactly 1 cycle in DONE, then return to IDLE.
REQ-031 SHALL set err_tlast when an accepted beat has S_AXIS_TLAST != core_eof; the frame SHALL continue.
REQ-032 SHALL hold state, counters and outputs when enable=0, except combinational deassertion of S_AXIS_TREADY.
REQ-033 SHALL ignore start outside IDLE.
REQ-034 SHALL size counters to $clog2 of their maximum plus 1 bit, and never overflow.

Reset
REQ-035 SHALL, on ARESET=1 at any clock edge (including mid-frame), enter IDLE with all counters 0, err_tlast=0, and frame_done=0.
REQ-036 SHALL have combinational outputs evaluate to 0 while reset is held.

Structure
REQ-037 SHALL place the state enum and the default IMG_WIDTH/IMG_HEIGHT constants in shared package haze_pkg.
REQ-038 SHALL instantiate one sub-module, haze_xy_counter (x/y with wrap and eol/eof flags), used for the input position.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2)
REQ-039 SHALL test: start, 8 beats, ale_done, 8 beats, 8 output beats -> core_pass 0 then 1; core_eof on beats 8 and 16; M_AXIS_TLAST on output beat 8; frame_done one cycle.
REQ-040 SHALL test: ale_done pulsed during PASS1 -> ignored; sequencer stays in ALE_WAIT after beat 8 until a new ale_done.
REQ-041 SHALL test: TLAST on beat 5 of pass 1 -> err_tlast=1 and stays 1; next start clears it.
REQ-042 SHALL test: enable=0 for 3 cycles mid-line with TVALID=1 -> TREADY=0, x unchanged, no beat lost.
REQ-043 SHALL test: ARESET asserted at pass-2 beat 3 -> next cycle busy=0, TREADY=0; a new start restarts at PASS1 with core_sof.
REQ-044 SHALL test: core_ready toggling every cycle -> exactly 8 core_valid per pass, core_eol on beats 4 and 8.
